// File: rtl/down_counter_ctrl.sv
// down_counter_ctrl: loadable down-counting timer.
// A start edge loads a value and the timer counts it down to zero, emitting a
// registered one-cycle done pulse on the terminal edge. The timer runs either
// one-shot or auto-reload (periodic). It also supports pause/hold and abort.
// Optional feature macro: DOWN_COUNTER_LOOPS_EN adds a saturating 'loops'
// output that counts auto-reload periods.
module down_counter_ctrl #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] init_val,
    input  logic         auto_reload,
    input  logic         pause,
    input  logic         abort,
    output logic [N-1:0] count,
    output logic         busy,
    output logic         done,
    output logic         zero
`ifdef DOWN_COUNTER_LOOPS_EN
    ,
    output logic [N-1:0] loops
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [N-1:0] CNT_ZERO = '0;
    localparam logic [N-1:0] CNT_ONE  = N'(1);

    state_t         state_reg;
    logic [N-1:0]   count_reg;
    logic [N-1:0]   reload_val_reg;
    logic           mode_reg;
    logic           done_reg;

    // The terminal edge of a running count: RUN, not pausing, count at 1.
    // Abort and start take precedence over this event.
    logic           terminal_edge;
    assign terminal_edge = (state_reg == RUN) && !pause && (count_reg == CNT_ONE)
                           && !abort && !start;

    assign count = count_reg;
    assign busy  = (state_reg != IDLE);
    assign done  = done_reg;
    assign zero  = (count_reg == CNT_ZERO);

    // Main control FSM; priority abort > start > pause > decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            count_reg      <= CNT_ZERO;
            reload_val_reg <= CNT_ZERO;
            mode_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (abort) begin
                state_reg <= IDLE;
                count_reg <= CNT_ZERO;
            end else if (start) begin
                reload_val_reg <= init_val;
                mode_reg       <= auto_reload;
                if (init_val != CNT_ZERO) begin
                    count_reg <= init_val;
                    state_reg <= RUN;
                end else begin
                    // A zero load completes at once and never enters RUN.
                    count_reg <= CNT_ZERO;
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
            end else begin
                case (state_reg)
                    IDLE: begin
                        state_reg <= IDLE;
                    end
                    RUN: begin
                        if (pause) begin
                            state_reg <= HOLD;
                        end else if (count_reg > CNT_ONE) begin
                            count_reg <= count_reg - CNT_ONE;
                        end else if (count_reg == CNT_ONE) begin
                            done_reg <= 1'b1;
                            if (mode_reg) begin
                                count_reg <= reload_val_reg;
                            end else begin
                                count_reg <= CNT_ZERO;
                                state_reg <= IDLE;
                            end
                        end else begin
                            // Zero count in RUN is unreachable; fall back to IDLE.
                            state_reg <= IDLE;
                        end
                    end
                    HOLD: begin
                        // The exit edge only returns to RUN. Decrementing
                        // resumes on the following edge.
                        if (!pause) begin
                            state_reg <= RUN;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        count_reg <= CNT_ZERO;
                    end
                endcase
            end
        end
    end

`ifdef DOWN_COUNTER_LOOPS_EN
    localparam logic [N-1:0] LOOPS_MAX = '1;
    logic [N-1:0] loops_reg;

    assign loops = loops_reg;

    // Count completed auto-reload periods, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loops_reg <= CNT_ZERO;
        end else if (abort || start) begin
            loops_reg <= CNT_ZERO;
        end else if (terminal_edge && mode_reg && (loops_reg != LOOPS_MAX)) begin
            loops_reg <= loops_reg + CNT_ONE;
        end
    end
`else
    logic unused_terminal;
    assign unused_terminal = terminal_edge;
`endif

endmodule

// File: tb/tb_down_counter_ctrl.sv
// Directed testbench for down_counter_ctrl (N = 6) with hand-computed expectations.
module tb_down_counter_ctrl;

    localparam int N = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] init_val;
    logic         auto_reload;
    logic         pause;
    logic         abort;
    logic [N-1:0] count;
    logic         busy;
    logic         done;
    logic         zero;
`ifdef DOWN_COUNTER_LOOPS_EN
    logic [N-1:0] loops;
`endif

    int check_cnt = 0;
    int pass_cnt  = 0;

    down_counter_ctrl #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .init_val    (init_val),
        .auto_reload (auto_reload),
        .pause       (pause),
        .abort       (abort),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .zero        (zero)
`ifdef DOWN_COUNTER_LOOPS_EN
        ,
        .loops       (loops)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        check_cnt++;
        if (got == exp) begin
            pass_cnt++;
            $display("ok   %-16s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("FAIL %-16s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input int c, input int b, input int d);
        check({tag, ".count"}, int'(count), c);
        check({tag, ".busy"},  int'(busy),  b);
        check({tag, ".done"},  int'(done),  d);
    endtask

    initial begin
        int done_seen;
        int zero_seen;
        rst = 1'b0; start = 1'b0; init_val = '0; auto_reload = 1'b0;
        pause = 1'b0; abort = 1'b0;

        // Reset state
        #2 rst = 1'b1;
        #1;
        chk_state("reset", 0, 0, 0);
        check("reset.zero", int'(zero), 1);
        tick();
        rst = 1'b0;
        tick();

        // One-shot with V=3; the mid-run init_val change must not matter
        start = 1'b1; init_val = 6'd3; auto_reload = 1'b0;
        tick();
        start = 1'b0; init_val = 6'd50;
        chk_state("os.e0", 3, 1, 0);
        tick(); chk_state("os.e1", 2, 1, 0);
        tick(); chk_state("os.e2", 1, 1, 0);
        tick(); chk_state("os.e3", 0, 0, 1);
        check("os.zero", int'(zero), 1);
        tick(); chk_state("os.e4", 0, 0, 0);

        // Auto-reload with V=2, run for 8 edges
        start = 1'b1; init_val = 6'd2; auto_reload = 1'b1;
        tick();
        start = 1'b0; auto_reload = 1'b0;
        check("ar.e0.count", int'(count), 2);
        done_seen = 0; zero_seen = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("ar.e%0d.count", k), int'(count), (k % 2 == 1) ? 1 : 2);
            check($sformatf("ar.e%0d.done", k), int'(done), (k % 2 == 0) ? 1 : 0);
            done_seen += int'(done);
            zero_seen += int'(zero);
        end
        check("ar.pulses", done_seen, 4);
        check("ar.zero_seen", zero_seen, 0);
        check("ar.busy", int'(busy), 1);
`ifdef DOWN_COUNTER_LOOPS_EN
        check("ar.loops", int'(loops), 4);
`endif
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_state("ar.abort", 0, 0, 0);
`ifdef DOWN_COUNTER_LOOPS_EN
        check("ar.loops_clr", int'(loops), 0);
`endif

        // Pause for 3 cycles at count=3
        start = 1'b1; init_val = 6'd4;
        tick();
        start = 1'b0;
        chk_state("pz.e0", 4, 1, 0);
        tick(); chk_state("pz.e1", 3, 1, 0);
        pause = 1'b1;
        tick(); chk_state("pz.h1", 3, 1, 0);
        tick(); chk_state("pz.h2", 3, 1, 0);
        tick(); chk_state("pz.h3", 3, 1, 0);
        pause = 1'b0;
        tick(); chk_state("pz.exit", 3, 1, 0);
        tick(); chk_state("pz.r1", 2, 1, 0);
        tick(); chk_state("pz.r2", 1, 1, 0);
        tick(); chk_state("pz.r3", 0, 0, 1);

        // Abort beats start in RUN at count=5
        start = 1'b1; init_val = 6'd6;
        tick();
        start = 1'b0;
        tick(); chk_state("pr.run", 5, 1, 0);
        start = 1'b1; abort = 1'b1; init_val = 6'd9;
        tick();
        start = 1'b0; abort = 1'b0;
        chk_state("pr.abort", 0, 0, 0);
        // Zero load: single done pulse, never busy
        start = 1'b1; init_val = 6'd0;
        tick();
        start = 1'b0;
        chk_state("pr.zload", 0, 0, 1);
        tick(); chk_state("pr.zload2", 0, 0, 0);

        // Restart at count=2 with 7
        start = 1'b1; init_val = 6'd4;
        tick();
        start = 1'b0;
        tick(); tick();
        check("rs.pre", int'(count), 2);
        start = 1'b1; init_val = 6'd7;
        tick();
        start = 1'b0;
        chk_state("rs.load", 7, 1, 0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("rs.e%0d.count", k), int'(count), 7 - k);
            check($sformatf("rs.e%0d.done", k), int'(done), (k == 7) ? 1 : 0);
        end

        // Asynchronous reset mid-run, between edges
        start = 1'b1; init_val = 6'd6;
        tick();
        start = 1'b0;
        tick(); tick();
        check("ar_rst.pre", int'(count), 4);
        #2 rst = 1'b1;
        #1;
        chk_state("ar_rst", 0, 0, 0);
        check("ar_rst.zero", int'(zero), 1);
        #1 rst = 1'b0;
        tick();
        chk_state("ar_rst.post", 0, 0, 0);

        // Maximum load 63: done exactly 63 edges after start
        start = 1'b1; init_val = 6'd63;
        tick();
        start = 1'b0;
        check("max.load", int'(count), 63);
        done_seen = 0;
        for (int k = 1; k <= 62; k++) begin
            tick();
            done_seen += int'(done);
        end
        check("max.early_done", done_seen, 0);
        check("max.e62.count", int'(count), 1);
        tick();
        chk_state("max.e63", 0, 0, 1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
